// File: rtl/j68_decode_loader.sv
// j68_decode_loader
//   Writer side of the 256 x 36 decode table. Receives a framed byte stream
//   from the host/debug channel and writes 36-bit entries into the writable
//   decode RAM that stands in for the fixed decode ROM. The CPU-side read port
//   is not touched here.
//
//   Frame: SYNC, start address, count-1, count x 5 data bytes (big-endian),
//   checksum (mod-256 sum of the data bytes only).
//
// Parameters
//   SYNC_BYTE  frame start byte; any other byte seen while idle is dropped
//   TIMEOUT    max idle cycles between bytes inside a frame; 0 disables it
//
// Ports
//   clock      single clock, rising edge
//   reset      synchronous, active-high
//   s_data     input byte
//   s_valid    byte valid; transferred when s_valid & s_ready
//   s_ready    loader accepts a byte this cycle (registered)
//   abort      synchronous frame abort
//   ram_we     one-cycle RAM write strobe
//   ram_addr   RAM write address
//   ram_data   RAM write data
//   busy       frame in progress
//   done       one-cycle pulse: frame completed with good checksum
//   error      one-cycle pulse: bad checksum, timeout or abort mid-frame
//   words      words written in the current/last frame (0..256)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | hunting for SYNC_BYTE, other bytes discarded
// ST_ADDR  | next byte is the base RAM address
// ST_CNT   | next byte is word count minus one
// ST_DATA  | collecting 5-byte words, one RAM write per completed word
// ST_CHK   | next byte is the checksum, then pulse done/error
module j68_decode_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] TIMEOUT   = 16'd4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        abort,
  output logic        ram_we,
  output logic [7:0]  ram_addr,
  output logic [35:0] ram_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  words
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_CNT  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        s_ready_q, s_ready_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic [35:0] ram_data_q, ram_data_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [8:0]  words_q, words_d;
  logic [7:0]  base_q, base_d;
  logic [8:0]  remaining_q, remaining_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  // Only the low nibble of byte 0 and bytes 1..3 ever reach the RAM, so the
  // assembly register keeps just those 28 bits; byte 4 is taken straight
  // from the input on the final handshake.
  logic [27:0] asm_q, asm_d;
  logic [15:0] timer_q, timer_d;

  logic        byte_acc;
  logic [15:0] timer_inc;

  assign byte_acc  = s_valid & s_ready_q;
  assign timer_inc = timer_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    s_ready_d   = 1'b1;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    words_d     = words_q;
    base_d      = base_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    asm_d       = asm_q;
    timer_d     = timer_q;

    if ((state_q != ST_IDLE) && abort) begin
      // Abort beats a same-cycle byte; the byte is simply not consumed.
      state_d = ST_IDLE;
      error_d = 1'b1;
      timer_d = 16'd0;
    end else if (byte_acc) begin
      timer_d = 16'd0;
      unique case (state_q)
        ST_IDLE: begin
          if (s_data == SYNC_BYTE) begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          base_d  = s_data;
          words_d = 9'd0;
          state_d = ST_CNT;
        end
        ST_CNT: begin
          remaining_d = {1'b0, s_data} + 9'd1;
          sum_d       = 8'd0;
          idx_d       = 3'd0;
          state_d     = ST_DATA;
        end
        ST_DATA: begin
          asm_d = {asm_q[19:0], s_data};
          sum_d = sum_q + s_data;
          if (idx_q == 3'd4) begin
            ram_we_d    = 1'b1;
            ram_data_d  = {asm_q, s_data};
            ram_addr_d  = base_q + words_q[7:0];
            words_d     = words_q + 9'd1;
            remaining_d = remaining_q - 9'd1;
            idx_d       = 3'd0;
            if (remaining_q == 9'd1) begin
              state_d = ST_CHK;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        ST_CHK: begin
          if (s_data == sum_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if ((TIMEOUT != 16'd0) && (timer_inc == TIMEOUT)) begin
        state_d = ST_IDLE;
        error_d = 1'b1;
        timer_d = 16'd0;
      end else begin
        timer_d = timer_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 8'd0;
      ram_data_q  <= 36'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      words_q     <= 9'd0;
      base_q      <= 8'd0;
      remaining_q <= 9'd0;
      idx_q       <= 3'd0;
      sum_q       <= 8'd0;
      asm_q       <= 28'd0;
      timer_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      done_q      <= done_d;
      error_q     <= error_d;
      words_q     <= words_d;
      base_q      <= base_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      asm_q       <= asm_d;
      timer_q     <= timer_d;
    end
  end

  // busy comes straight from the state so it drops in the same cycle the
  // registered done/error pulse appears.
  assign busy     = (state_q != ST_IDLE);
  assign s_ready  = s_ready_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign done     = done_q;
  assign error    = error_q;
  assign words    = words_q;

endmodule

// File: tb/tb_j68_decode_loader.sv
// Testbench for j68_decode_loader: table of directed frames, hand-written
// multi-cycle corner cases (timeout, abort, reset) and randomized frames
// checked against a frame-level model of the expected RAM writes.
module tb_j68_decode_loader;

  localparam logic [15:0] TMO = 16'd16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        abort = 1'b0;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [35:0] ram_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  words;

  always #5 clock = ~clock;

  j68_decode_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
    .clock    (clock),
    .reset    (reset),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .abort    (abort),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .words    (words)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [35:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  base;
    int          n;
    logic [39:0] w0;
    logic [7:0]  sum_delta;
    int          garbage;
    int          exp_done;
    int          exp_err;
    logic [8:0]  exp_words;
    logic [7:0]  exp_last_addr;
    logic [35:0] exp_last_data;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Written only by the monitor.
  wr_t got_q[$];
  int  done_cnt   = 0;
  int  err_cnt    = 0;
  int  excl_viol  = 0;
  int  busy_viol  = 0;

  // Results of the last run_frame call.
  int          last_done_n;
  int          last_err_n;
  logic [7:0]  last_addr;
  logic [35:0] last_data;

  always @(negedge clock) begin
    if (!reset) begin
      if (ram_we) got_q.push_back('{ram_addr, ram_data});
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (done && error) excl_viol++;
      if ((done || error) && busy) busy_viol++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    @(negedge clock);
    s_data  = b;
    s_valid = 1'b1;
    w = 0;
    while (!s_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (!s_ready) begin
      check("s_ready_wait", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1 s_valid = 1'b0;
    end
  endtask

  task automatic send_byte_abort(input logic [7:0] b);
    @(negedge clock);
    s_data  = b;
    s_valid = 1'b1;
    abort   = 1'b1;
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    repeat (n) @(posedge clock);
    @(negedge clock);
    check("rst_s_ready",  64'(s_ready),  64'd0);
    check("rst_ram_we",   64'(ram_we),   64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_error",    64'(error),    64'd0);
    check("rst_words",    64'(words),    64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_data", 64'(ram_data), 64'd0);
    reset = 1'b0;
    check("s_ready_first_cycle", 64'(s_ready), 64'd0);
    @(negedge clock);
    check("s_ready_second_cycle", 64'(s_ready), 64'd1);
  endtask

  // Drives one complete frame and checks the RAM writes, pulses and word
  // count against what the frame should produce.
  task automatic run_frame(input logic [7:0] base, input int n, input logic [39:0] w0,
                           input bit rnd, input logic [7:0] sum_delta,
                           input int garbage, input int max_gap);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [7:0]  g;
    logic [39:0] w;
    int          done0, err0, got0, ngot, ok;
    wr_t         exp_q[$];
    done0 = done_cnt;
    err0  = err_cnt;
    got0  = got_q.size();
    for (int i = 0; i < garbage; i++) begin
      if (rnd) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
      end else begin
        case (i % 3)
          0:       g = 8'h00;
          1:       g = 8'hFF;
          default: g = 8'h5A;
        endcase
      end
      send_byte(g);
      idle((max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    end
    send_byte(8'hA5);
    send_byte(base);
    send_byte(8'(n - 1));
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = rnd ? {8'($urandom), 32'($urandom)} : (w0 + 40'(i));
      exp_q.push_back('{8'((int'(base) + i) % 256), w[35:0]});
      for (int k = 0; k < 5; k++) begin
        b = w[8*(4-k) +: 8];
        sum = sum + b;
        send_byte(b);
        idle((max_gap > 0) ? $urandom_range(0, max_gap) : 0);
      end
    end
    send_byte(sum + sum_delta);
    idle(3);
    @(negedge clock);
    ngot = got_q.size() - got0;
    check("write_count", 64'(ngot), 64'(exp_q.size()));
    for (int i = 0; i < ngot && i < exp_q.size(); i++) begin
      check("write_addr", 64'(got_q[got0+i].addr), 64'(exp_q[i].addr));
      check("write_data", 64'(got_q[got0+i].data), 64'(exp_q[i].data));
    end
    ok = (sum_delta == 8'd0) ? 1 : 0;
    last_done_n = done_cnt - done0;
    last_err_n  = err_cnt - err0;
    check("frame_done", 64'(last_done_n), 64'(ok));
    check("frame_error", 64'(last_err_n), 64'(1 - ok));
    check("frame_words", 64'(words), 64'(n));
    check("frame_busy_after", 64'(busy), 64'd0);
    if (ngot > 0) begin
      last_addr = got_q[got_q.size()-1].addr;
      last_data = got_q[got_q.size()-1].data;
    end else begin
      last_addr = 8'hxx;
      last_data = 36'hx;
    end
  endtask

  initial begin
    vec_t vecs[6];
    int d0, e0, g0;

    vecs[0] = '{8'h10, 1,   40'h0F12345678, 8'h00, 0, 1, 0, 9'd1,   8'h10, 36'hF12345678};
    vecs[1] = '{8'hFE, 3,   40'h0123456789, 8'h00, 0, 1, 0, 9'd3,   8'h00, 36'h12345678B};
    vecs[2] = '{8'h10, 1,   40'h0F12345678, 8'hF9, 0, 0, 1, 9'd1,   8'h10, 36'hF12345678};
    vecs[3] = '{8'h10, 1,   40'h0F12345678, 8'h00, 3, 1, 0, 9'd1,   8'h10, 36'hF12345678};
    vecs[4] = '{8'hFF, 2,   40'h0000000001, 8'h00, 0, 1, 0, 9'd2,   8'h00, 36'h000000002};
    vecs[5] = '{8'h80, 256, 40'hAB00000000, 8'h00, 0, 1, 0, 9'd256, 8'h7F, 36'hB000000FF};

    do_reset(3);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].base, vecs[i].n, vecs[i].w0, 1'b0, vecs[i].sum_delta,
                vecs[i].garbage, 0);
      check("tv_done",      64'(last_done_n), 64'(vecs[i].exp_done));
      check("tv_error",     64'(last_err_n),  64'(vecs[i].exp_err));
      check("tv_words",     64'(words),       64'(vecs[i].exp_words));
      check("tv_last_addr", 64'(last_addr),   64'(vecs[i].exp_last_addr));
      check("tv_last_data", 64'(last_data),   64'(vecs[i].exp_last_data));
    end

    // Stall of TIMEOUT cycles after the 2nd data byte.
    d0 = done_cnt; e0 = err_cnt; g0 = got_q.size();
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'h0F); send_byte(8'h12);
    idle(16);
    idle(2);
    @(negedge clock);
    check("tmo_error",    64'(err_cnt - e0),        64'd1);
    check("tmo_done",     64'(done_cnt - d0),       64'd0);
    check("tmo_no_write", 64'(got_q.size() - g0),   64'd0);
    check("tmo_busy",     64'(busy),                64'd0);
    run_frame(8'h21, 1, 40'h0F12345678, 1'b0, 8'h00, 0, 0);
    check("tmo_recover_done", 64'(last_done_n), 64'd1);

    // Byte arriving on the very cycle the timer would expire wins.
    d0 = done_cnt; e0 = err_cnt; g0 = got_q.size();
    send_byte(8'hA5); send_byte(8'h22); send_byte(8'h00);
    send_byte(8'h0F);
    idle(15);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h23);
    idle(3);
    @(negedge clock);
    check("tmo_edge_error", 64'(err_cnt - e0),      64'd0);
    check("tmo_edge_done",  64'(done_cnt - d0),     64'd1);
    check("tmo_edge_write", 64'(got_q.size() - g0), 64'd1);

    // Abort after the 3rd data byte.
    d0 = done_cnt; e0 = err_cnt; g0 = got_q.size();
    send_byte(8'hA5); send_byte(8'h30); send_byte(8'h00);
    send_byte(8'h0F); send_byte(8'h12); send_byte(8'h34);
    pulse_abort();
    idle(2);
    @(negedge clock);
    check("abort_error",    64'(err_cnt - e0),      64'd1);
    check("abort_done",     64'(done_cnt - d0),     64'd0);
    check("abort_no_write", 64'(got_q.size() - g0), 64'd0);
    check("abort_busy",     64'(busy),              64'd0);

    // Abort while idle does nothing.
    e0 = err_cnt;
    pulse_abort();
    idle(2);
    @(negedge clock);
    check("abort_idle_error", 64'(err_cnt - e0), 64'd0);
    check("abort_idle_busy",  64'(busy),         64'd0);

    // Abort with a byte, one cycle after a completed word: write still lands.
    d0 = done_cnt; e0 = err_cnt; g0 = got_q.size();
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h01);
    send_byte(8'h0F); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte_abort(8'h99);
    idle(2);
    @(negedge clock);
    check("abort_pend_writes", 64'(got_q.size() - g0), 64'd1);
    if (got_q.size() > g0) begin
      check("abort_pend_addr", 64'(got_q[g0].addr), 64'h40);
      check("abort_pend_data", 64'(got_q[g0].data), 64'hF12345678);
    end
    check("abort_pend_error", 64'(err_cnt - e0),  64'd1);
    check("abort_pend_done",  64'(done_cnt - d0), 64'd0);
    check("abort_pend_words", 64'(words),         64'd1);
    check("abort_pend_busy",  64'(busy),          64'd0);

    // Reset mid-DATA: no write, no pulse, everything back to reset values.
    d0 = done_cnt; e0 = err_cnt; g0 = got_q.size();
    send_byte(8'hA5); send_byte(8'h50); send_byte(8'h00);
    send_byte(8'h0F); send_byte(8'h12);
    do_reset(2);
    idle(2);
    @(negedge clock);
    check("rst_mid_no_write", 64'(got_q.size() - g0), 64'd0);
    check("rst_mid_error",    64'(err_cnt - e0),      64'd0);
    check("rst_mid_done",     64'(done_cnt - d0),     64'd0);
    check("rst_mid_busy",     64'(busy),              64'd0);
    run_frame(8'h51, 2, 40'h0F00000001, 1'b0, 8'h00, 0, 0);

    // Randomized frames against the frame-level model.
    for (int i = 0; i < 25; i++) begin
      run_frame(8'($urandom_range(0, 255)), $urandom_range(1, 6), 40'd0, 1'b1,
                ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                $urandom_range(0, 2), 3);
    end

    check("pulse_exclusive_viol", 64'(excl_viol), 64'd0);
    check("busy_during_pulse_viol", 64'(busy_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
